// File: rtl/tick_sequencer.sv
// -----------------------------------------------------------------------------
// tick_sequencer
//
// Generates a one-cycle clock-enable pulse ("tick") for a slow processor.
// In RUN a divide counter produces one tick every P+1 clocks. In HALT a
// synchronized push-button produces single ticks through a one-cycle STEP
// state. The period register can only be rewritten while halted.
//
// Parameters
//   N          width of the period register and divide counter
//   DEF_PERIOD period register value after reset
//
// Ports
//   clock       system clock, rising-edge active
//   reset       asynchronous, active-high reset
//   run_sw      level: 1 = free-running ticks, 0 = halt
//   step_btn    asynchronous push-button; each rising edge requests one tick
//   halt_req    level from the processor: 1 forces halt
//   cfg_valid   period-write request
//   cfg_period  new period value
//   cfg_ready   high while halted; a write is accepted when cfg_valid is high too
//   tick        registered one-cycle clock-enable pulse
//   tick_count  number of ticks issued, modulo 2^16
//   state       HALT=00, RUN=01, STEP=10
// -----------------------------------------------------------------------------
module tick_sequencer #(
    parameter int unsigned N          = 17,
    parameter int unsigned DEF_PERIOD = 99999
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         run_sw,
    input  logic         step_btn,
    input  logic         halt_req,
    input  logic         cfg_valid,
    input  logic [N-1:0] cfg_period,
    output logic         cfg_ready,
    output logic         tick,
    output logic [15:0]  tick_count,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_BAD  = 2'b11
    } state_e;

    localparam logic [N-1:0] PERIOD_RST = N'(DEF_PERIOD);

    state_e        state_q,      state_d;
    logic [N-1:0]  cnt_q,        cnt_d;
    logic [N-1:0]  period_q,     period_d;
    logic          tick_q,       tick_d;
    logic [15:0]   tick_count_q, tick_count_d;

    // Button synchronizer (two flops) plus the previous synchronized value
    // used by the rising-edge detector.
    logic          sync1_q, sync2_q, edge_q;
    logic          step_evt;

    assign step_evt = sync2_q & ~edge_q;

    // Next-state logic for the sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        tick_d       = 1'b0;

        unique case (state_q)
            ST_HALT: begin
                if (cfg_valid) begin
                    period_d = cfg_period;
                end
                // RUN wins over a simultaneous step request.
                if (run_sw && !halt_req) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (step_evt && !run_sw && !halt_req) begin
                    state_d = ST_STEP;
                end
            end

            ST_RUN: begin
                // The tick for the final RUN cycle is registered even when
                // this same edge leaves RUN.
                tick_d = (cnt_q == period_q);
                if (!run_sw || halt_req) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end else if (cnt_q == period_q) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + N'(1);
                end
            end

            ST_STEP: begin
                tick_d  = 1'b1;
                state_d = ST_HALT;
            end

            default: begin
                // Unreachable encoding: recover to HALT.
                state_d = ST_HALT;
                cnt_d   = '0;
            end
        endcase

        // The counter advances on the same edge that registers the tick, so
        // both outputs change together.
        tick_count_d = tick_d ? (tick_count_q + 16'd1) : tick_count_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HALT;
            cnt_q        <= '0;
            period_q     <= PERIOD_RST;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            edge_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            sync1_q      <= step_btn;
            sync2_q      <= sync1_q;
            edge_q       <= sync2_q;
        end
    end

    assign cfg_ready  = (state_q == ST_HALT);
    assign tick       = tick_q;
    assign tick_count = tick_count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tick_sequencer
//
// Directed scenarios plus a randomized phase, all compared cycle by cycle
// against a behavioural model. The model tracks the mode, the number of cycles
// spent in RUN (a tick is due whenever that age modulo P+1 equals P) and a
// short history of sampled button values.
// -----------------------------------------------------------------------------
module tb_tick_sequencer;

    localparam int N = 17;

    logic          clock      = 1'b0;
    logic          reset      = 1'b0;
    logic          run_sw     = 1'b0;
    logic          step_btn   = 1'b0;
    logic          halt_req   = 1'b0;
    logic          cfg_valid  = 1'b0;
    logic [N-1:0]  cfg_period = '0;
    logic          cfg_ready;
    logic          tick;
    logic [15:0]   tick_count;
    logic [1:0]    state;

    tick_sequencer #(
        .N          (N),
        .DEF_PERIOD (99999)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .halt_req   (halt_req),
        .cfg_valid  (cfg_valid),
        .cfg_period (cfg_period),
        .cfg_ready  (cfg_ready),
        .tick       (tick),
        .tick_count (tick_count),
        .state      (state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_mode;     // 0 halt, 1 run, 2 step
    int m_age;      // cycles elapsed since entering RUN
    int m_p;        // period
    bit m_tick;
    int m_cnt;
    bit hist [3];   // button samples: [0] newest edge, [2] oldest

    function automatic void model_reset();
        m_mode = 0;
        m_age  = 0;
        m_p    = 99999;
        m_tick = 1'b0;
        m_cnt  = 0;
        for (int i = 0; i < 3; i++) hist[i] = 1'b0;
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    function automatic void model_step();
        bit evt;
        bit nt;
        // A step event is a button sample that is high two edges ago and was
        // low three edges ago.
        evt = hist[1] && !hist[2];
        nt  = 1'b0;
        case (m_mode)
            1: begin
                nt = ((m_age % (m_p + 1)) == m_p);
                if (!run_sw || halt_req) m_mode = 0;
                else                     m_age++;
            end
            2: begin
                nt     = 1'b1;
                m_mode = 0;
            end
            default: begin
                if (cfg_valid) m_p = int'(cfg_period);
                if (run_sw && !halt_req) begin
                    m_mode = 1;
                    m_age  = 0;
                end else if (evt && !run_sw && !halt_req) begin
                    m_mode = 2;
                end
            end
        endcase
        m_tick = nt;
        if (nt) m_cnt = (m_cnt + 1) % 65536;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = step_btn;
    endfunction

    task automatic compare_model();
        check("tick",       tick,       m_tick);
        check("tick_count", tick_count, m_cnt);
        check("state",      state,      m_mode);
        check("cfg_ready",  cfg_ready,  (m_mode == 0));
    endtask

    // Called at a falling edge; inputs are already applied.
    task automatic step_cycle(input bit do_cmp);
        model_step();
        @(posedge clock);
        @(negedge clock);
        if (do_cmp) compare_model();
    endtask

    // Asserts reset between clock edges, checks outputs right away, then
    // releases it on a falling edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst_state", state,      2'b00);
        check("rst_tick",  tick,       1'b0);
        check("rst_count", tick_count, 16'h0000);
        check("rst_ready", cfg_ready,  1'b1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    int nt_sum;

    initial begin
        model_reset();
        do_reset();

        // Period 3: ticks on samples 5, 9, 13 after the RUN entry edge.
        cfg_valid = 1'b1; cfg_period = 3;
        step_cycle(1);
        cfg_valid = 1'b0;
        run_sw = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step_cycle(1);
            check("p3_tick", tick, (k == 5 || k == 9 || k == 13));
        end
        check("p3_count", tick_count, 3);
        run_sw = 1'b0;
        step_cycle(1);
        step_cycle(1);

        // Period 0: ten RUN cycles give ten consecutive ticks, then silence.
        cfg_valid = 1'b1; cfg_period = 0;
        step_cycle(1);
        cfg_valid = 1'b0;
        nt_sum = 0;
        run_sw = 1'b1;
        step_cycle(1);
        nt_sum += int'(tick);
        repeat (9) begin
            step_cycle(1);
            nt_sum += int'(tick);
        end
        run_sw = 1'b0;
        repeat (6) begin
            step_cycle(1);
            nt_sum += int'(tick);
        end
        check("p0_ticks", nt_sum, 10);
        check("p0_state", state, 2'b00);
        check("p0_count", tick_count, 13);

        // Single steps: each tick appears four edges after the button rises.
        repeat (3) begin
            step_btn = 1'b1;
            for (int k = 1; k <= 10; k++) begin
                if (k == 6) step_btn = 1'b0;
                step_cycle(1);
                check("step_tick", tick, (k == 4));
            end
        end
        check("step_count", tick_count, 16);

        // Period 7, halt_req at C=4: no tick, and buttons ignored while held.
        cfg_valid = 1'b1; cfg_period = 7;
        step_cycle(1);
        cfg_valid = 1'b0;
        run_sw = 1'b1;
        for (int k = 1; k <= 5; k++) step_cycle(1);
        halt_req = 1'b1;
        step_cycle(1);
        check("hreq_state", state, 2'b00);
        check("hreq_tick",  tick,  1'b0);
        nt_sum = 0;
        step_btn = 1'b1;
        repeat (5) begin
            step_cycle(1);
            nt_sum += int'(tick);
        end
        step_btn = 1'b0;
        repeat (5) begin
            step_cycle(1);
            nt_sum += int'(tick);
        end
        check("hreq_step_ticks", nt_sum, 0);
        run_sw = 1'b0;
        step_cycle(1);
        halt_req = 1'b0;
        step_cycle(1);
        check("hreq_count", tick_count, 16);

        // Period write during RUN is held off, then taken in the first HALT cycle.
        run_sw = 1'b1;
        repeat (3) step_cycle(1);
        cfg_valid = 1'b1; cfg_period = 5;
        repeat (3) begin
            step_cycle(1);
            check("cfg_ready_run", cfg_ready, 1'b0);
        end
        run_sw = 1'b0;
        step_cycle(1);
        check("cfg_ready_halt", cfg_ready, 1'b1);
        step_cycle(1);
        cfg_valid = 1'b0;
        run_sw = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step_cycle(1);
            check("p5_tick", tick, (k == 7 || k == 13));
        end
        run_sw = 1'b0;
        step_cycle(1);
        step_cycle(1);

        // Randomized phase with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) run_sw   = ~run_sw;
            if ($urandom_range(0, 29) == 0) halt_req = ~halt_req;
            if ($urandom_range(0, 5)  == 0) step_btn = ~step_btn;
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_period = N'($urandom_range(0, 6));
            if (i == 1500) do_reset();
            step_cycle(1);
        end

        // Counter wrap: fill to 0xFFFE with period 0, then three more ticks.
        run_sw = 1'b0; halt_req = 1'b0; step_btn = 1'b0; cfg_valid = 1'b0;
        repeat (6) step_cycle(1);
        cfg_valid = 1'b1; cfg_period = 0;
        step_cycle(1);
        cfg_valid = 1'b0;
        run_sw = 1'b1;
        step_cycle(1);
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFE; i++) step_cycle(0);
        compare_model();
        check("fill_count", tick_count, 16'hFFFE);
        step_cycle(1);
        check("wrap_ffff", tick_count, 16'hFFFF);
        step_cycle(1);
        check("wrap_0000", tick_count, 16'h0000);
        step_cycle(1);
        check("wrap_0001", tick_count, 16'h0001);
        check("wrap_tick", tick, 1'b1);

        // Reset in the middle of RUN clears everything at once.
        do_reset();
        repeat (3) step_cycle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_sequencer.md
TICK_SEQUENCER -- requirements
Module: tick_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 17, giving the width of the period register and divide counter.
REQ-002 The block SHALL have parameter DEF_PERIOD, default 99999, giving the period register value after reset.
REQ-003 The block SHALL have port clock  input  1  single system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port run_sw  input  1  level; 1 requests free-running ticks, 0 requests halt.
REQ-006 The block SHALL have port step_btn  input  1  asynchronous push-button; each rising edge requests one tick while halted.
REQ-007 The block SHALL have port halt_req  input  1  level from the processor; 1 forces halt.
REQ-008 The block SHALL have port cfg_valid  input  1  period-write request.
REQ-009 The block SHALL have port cfg_period  input  N  new period value.
REQ-010 The block SHALL have port cfg_ready  output  1  period write accepted this cycle when cfg_valid is also 1.
REQ-011 The block SHALL have port tick  output  1  registered one-cycle processor clock-enable pulse.
REQ-012 The block SHALL have port tick_count  output  16  number of ticks issued, modulo 2^16.
REQ-013 The block SHALL have port state  output  2  encoding HALT=00, RUN=01, STEP=10.

Function
REQ-014 The block SHALL hold an N-bit period register P and an N-bit divide counter C.
REQ-015 In RUN, C SHALL increment by 1 per cycle and SHALL wrap to 0 in the cycle after C==P.
REQ-016 tick SHALL be 1 in the cycle after a cycle with state==RUN and C==P, giving one tick every P+1 clocks; P=0 gives tick every cycle.
REQ-017 step_btn SHALL pass through a 2-flop synchronizer followed by a rising-edge detector, giving a 1-cycle step_evt pulse 3 cycles after the edge.
REQ-018 HALT->RUN SHALL occur when run_sw==1 and halt_req==0, with C cleared to 0.
REQ-019 RUN->HALT SHALL occur when run_sw==0 or halt_req==1, with C cleared to 0; a tick already registered from the final RUN cycle SHALL still appear.
REQ-020 HALT->STEP SHALL occur on step_evt when run_sw==0 and halt_req==0.
REQ-021 STEP SHALL last exactly one cycle, SHALL register tick=1 for the next cycle, and SHALL return to HALT unconditionally.
REQ-022 step_evt SHALL be ignored in RUN and in STEP; step_evt SHALL be ignored when halt_req==1.
REQ-023 If run_sw and step_evt are both active in HALT, RUN SHALL take priority.
REQ-024 cfg_ready SHALL equal (state==HALT) combinationally.
REQ-025 When cfg_valid and cfg_ready are both 1, P SHALL take cfg_period at the next edge; when cfg_ready is 0, the request SHALL have no effect and SHALL be held by the requester.
REQ-026 tick_count SHALL increment by 1 in the same cycle that tick is 1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-027 The encoding state=11 SHALL be unreachable, and any such value SHALL return to HALT on the next edge.

Reset
REQ-028 While reset is 1, the block SHALL hold state=HALT, C=0, P=DEF_PERIOD, tick=0, tick_count=0, and both synchronizer flops and the edge-detector flop at 0.
REQ-029 Reset asserted mid-RUN or mid-STEP SHALL take effect immediately without waiting for a clock edge, and no tick SHALL be issued for the interrupted operation.
REQ-030 After reset is released, the first transition SHALL be evaluated on the first rising clock edge.

Verification
REQ-031 Reset, write P=3 in HALT, set run_sw=1 -> tick on cycles 5, 9, 13 after the RUN entry edge; tick_count reaches 3.
REQ-032 P=0, RUN for 10 cycles, then run_sw=0 -> 10 consecutive ticks, then HALT with C=0 and no further ticks.
REQ-033 In HALT, 3 step_btn pulses each at least 4 cycles wide -> exactly 3 single-cycle ticks, each 4 cycles after its rising edge; tick_count=3.
REQ-034 P=7, RUN, halt_req=1 at C=4 -> state=HALT next cycle, no tick issued; step_btn while halt_req=1 -> no tick.
REQ-035 cfg_valid=1 with cfg_period=5 during RUN -> cfg_ready=0 and P unchanged; after halt, write accepted in the first HALT cycle.
REQ-036 Set tick_count to 0xFFFE, issue 3 ticks -> tick_count sequence 0xFFFF, 0x0000, 0x0001; assert reset mid-RUN -> all outputs at reset values immediately.
